// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the program/data memory arbiter.
package mem_arb_pkg;

    localparam int MEM_ADDR_W    = 5;
    localparam int MEM_DATA_W    = 8;
    localparam int DEF_MAX_BURST = 4;
    localparam int BCNT_W        = 4;

    typedef enum logic [1:0] {
        OWN_IDLE,
        OWN_CPU,
        OWN_EXT
    } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester port of the memory arbiter: one instance for the CPU, one for the external port.
interface mem_arbiter_if import mem_arb_pkg::*; #(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) ();

    // Handshake: req/we/addr/wdata are held until gnt=1 is sampled at a rising
    // edge; that edge completes the access. For reads, valid/rdata follow for
    // exactly one cycle after the grant cycle. Writes never raise valid.
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              valid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, valid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, valid, rdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// Fixed-priority CPU/external arbiter for the 32x8 memory with a starvation-bounding burst counter.
// Optional ARB_EXT_LOCK_EN adds an ext_lock input that keeps the external port in ownership.
module mem_arbiter import mem_arb_pkg::*; #(
    parameter int ADDR_W    = MEM_ADDR_W,
    parameter int DATA_W    = MEM_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst,
    mem_arbiter_if.slave      cpu,
    mem_arbiter_if.slave      ext,
`ifdef ARB_EXT_LOCK_EN
    input  logic              ext_lock,
`endif
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output owner_t            dbg_owner,
    output logic [BCNT_W-1:0] dbg_bcnt
);

    localparam logic [BCNT_W-1:0] BURST_LIM = BCNT_W'(MAX_BURST);

    owner_t            owner_q, owner_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic              cpu_win, ext_win;
    logic              locked;
    logic              burst_hit;

    logic              cpu_rd_q, ext_rd_q;
    logic [DATA_W-1:0] cpu_rdata_q, ext_rdata_q;

    always_comb begin
        locked    = 1'b0;
`ifdef ARB_EXT_LOCK_EN
        locked    = (owner_q == OWN_EXT) && ext_lock;
`endif
        burst_hit = (bcnt_q >= BURST_LIM);
        cpu_win   = 1'b0;
        ext_win   = 1'b0;
        if (!rst) begin
            if (locked) begin
                ext_win = ext.req;
            end else if (cpu.req && (!ext.req || !burst_hit)) begin
                cpu_win = 1'b1;
            end else if (ext.req) begin
                ext_win = 1'b1;
            end
        end
    end

    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_win) begin
            mem_rd    = ~cpu.we;
            mem_wr    = cpu.we;
            mem_addr  = cpu.addr;
            mem_wdata = cpu.wdata;
        end else if (ext_win) begin
            mem_rd    = ~ext.we;
            mem_wr    = ext.we;
            mem_addr  = ext.addr;
            mem_wdata = ext.wdata;
        end
    end

    assign cpu.gnt = cpu_win;
    assign ext.gnt = ext_win;

    // Owner records the last cycle's grant; it drives the lock window.
    always_comb begin
        owner_d = OWN_IDLE;
        if (cpu_win) begin
            owner_d = OWN_CPU;
        end else if (ext_win) begin
            owner_d = OWN_EXT;
        end
    end

    always_comb begin
        bcnt_d = bcnt_q;
        if (ext_win || !ext.req || locked) begin
            bcnt_d = '0;
        end else if (cpu_win && !burst_hit) begin
            bcnt_d = bcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_IDLE;
            bcnt_q  <= '0;
        end else begin
            owner_q <= owner_d;
            bcnt_q  <= bcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rd_q    <= 1'b0;
            ext_rd_q    <= 1'b0;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
        end else begin
            cpu_rd_q <= cpu_win & ~cpu.we;
            ext_rd_q <= ext_win & ~ext.we;
            if (cpu_win && !cpu.we) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (ext_win && !ext.we) begin
                ext_rdata_q <= mem_rdata;
            end
        end
    end

    // Gated by rst so a read granted just before reset never shows valid data.
    assign cpu.valid = cpu_rd_q & ~rst;
    assign ext.valid = ext_rd_q & ~rst;
    assign cpu.rdata = rst ? '0 : cpu_rdata_q;
    assign ext.rdata = rst ? '0 : ext_rdata_q;

    assign dbg_owner = owner_q;
    assign dbg_bcnt  = bcnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers push expected grants/read data, a monitor pops and compares.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk;
    logic rst;
    logic mem_rd, mem_wr;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    owner_t dbg_owner;
    logic [3:0] dbg_bcnt;
`ifdef ARB_EXT_LOCK_EN
    logic ext_lock;
`endif

    mem_arbiter_if cpu_if ();
    mem_arbiter_if ext_if ();

    mem_arbiter #(.MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu       (cpu_if.slave),
        .ext       (ext_if.slave),
`ifdef ARB_EXT_LOCK_EN
        .ext_lock  (ext_lock),
`endif
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .dbg_owner (dbg_owner),
        .dbg_bcnt  (dbg_bcnt)
    );

    // Clock / reset and memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [32];
    assign mem_rdata = mem_rd ? mem[mem_addr] : 8'h00;
    always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;

    // Scoreboard
    logic [16:0] exp_q[$];
    logic [9:0]  exp_rd_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_gnt(input logic c, input logic e, input logic we,
                            input logic [4:0] a, input logic [7:0] d);
        exp_q.push_back({c, e, ~we, we, a, d});
    endtask

    task automatic push_rd(input logic c, input logic [7:0] d);
        exp_rd_q.push_back({c, ~c, d});
    endtask

    // Monitor
    initial begin
        logic [16:0] obs, expv;
        logic [9:0]  obs_r, exp_r;
        forever begin
            @(negedge clk);
            if (cpu_if.gnt || ext_if.gnt) begin
                obs = {cpu_if.gnt, ext_if.gnt, mem_rd, mem_wr, mem_addr, mem_wdata};
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL grant: unexpected grant actual=%0h required=none", obs);
                end else begin
                    expv = exp_q.pop_front();
                    check("grant", 32'(obs), 32'(expv));
                end
            end
            if (cpu_if.valid || ext_if.valid) begin
                obs_r = {cpu_if.valid, ext_if.valid, cpu_if.valid ? cpu_if.rdata : ext_if.rdata};
                if (exp_rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rdata: unexpected valid actual=%0h required=none", obs_r);
                end else begin
                    exp_r = exp_rd_q.pop_front();
                    check("rdata", 32'(obs_r), 32'(exp_r));
                end
            end
        end
    end

    // Drivers
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic r, input logic we, input logic [4:0] a, input logic [7:0] d);
        cpu_if.req = r; cpu_if.we = we; cpu_if.addr = a; cpu_if.wdata = d;
    endtask

    task automatic set_ext(input logic r, input logic we, input logic [4:0] a, input logic [7:0] d);
        ext_if.req = r; ext_if.we = we; ext_if.addr = a; ext_if.wdata = d;
    endtask

    initial begin
        #60000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat;
        pat = 10'b10_0001_0000;  // bit i set: EXT expected in cycle i
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem[5] = 8'h3C;
`ifdef ARB_EXT_LOCK_EN
        ext_lock = 1'b0;
`endif
        // Reset with both requesting: nothing may be granted
        rst = 1'b1;
        set_cpu(1'b1, 1'b0, 5'd5, 8'h00);
        set_ext(1'b1, 1'b1, 5'd9, 8'h77);
        cycle();
        cycle();
        @(negedge clk);
        check("rst_cpu_gnt", 32'(cpu_if.gnt), 0);
        check("rst_ext_gnt", 32'(ext_if.gnt), 0);
        check("rst_mem_strobe", 32'({mem_rd, mem_wr}), 0);
        check("rst_valid", 32'({cpu_if.valid, ext_if.valid}), 0);
        check("rst_rdata", 32'({cpu_if.rdata, ext_if.rdata}), 0);
        check("rst_owner", 32'(dbg_owner), 32'(OWN_IDLE));
        check("rst_bcnt", 32'(dbg_bcnt), 0);
        cycle();
        rst = 1'b0;
        set_cpu(1'b0, 1'b0, 5'd0, 8'h00);
        set_ext(1'b0, 1'b0, 5'd0, 8'h00);
        @(negedge clk);
        check("idle_bus", 32'({mem_rd, mem_wr, mem_addr, mem_wdata}), 0);

        // CPU-only read of address 5
        cycle();
        set_cpu(1'b1, 1'b0, 5'd5, 8'h00);
        push_gnt(1'b1, 1'b0, 1'b0, 5'd5, 8'h00);
        push_rd(1'b1, 8'h3C);
        cycle();
        set_cpu(1'b0, 1'b0, 5'd0, 8'h00);
        @(negedge clk);
        check("owner_cpu", 32'(dbg_owner), 32'(OWN_CPU));
        cycle();
        @(negedge clk);
        check("owner_idle", 32'(dbg_owner), 32'(OWN_IDLE));

        // EXT-only write to 31, then CPU reads it back
        cycle();
        set_ext(1'b1, 1'b1, 5'd31, 8'hA5);
        push_gnt(1'b0, 1'b1, 1'b1, 5'd31, 8'hA5);
        cycle();
        set_ext(1'b0, 1'b0, 5'd0, 8'h00);
        set_cpu(1'b1, 1'b0, 5'd31, 8'h00);
        push_gnt(1'b1, 1'b0, 1'b0, 5'd31, 8'h00);
        push_rd(1'b1, 8'hA5);
        cycle();
        set_cpu(1'b0, 1'b0, 5'd0, 8'h00);
        cycle();
        cycle();

        // Both requesting for 10 cycles: C,C,C,C,E,C,C,C,C,E
        set_cpu(1'b1, 1'b0, 5'd5, 8'h00);
        set_ext(1'b1, 1'b1, 5'd7, 8'h11);
        for (int i = 0; i < 10; i++) begin
            if (pat[i]) push_gnt(1'b0, 1'b1, 1'b1, 5'd7, 8'h11);
            else begin
                push_gnt(1'b1, 1'b0, 1'b0, 5'd5, 8'h00);
                push_rd(1'b1, 8'h3C);
            end
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                @(negedge clk);
                check("bcnt_sat", 32'(dbg_bcnt), 4);
            end
            cycle();
        end
        set_cpu(1'b0, 1'b0, 5'd0, 8'h00);
        set_ext(1'b0, 1'b0, 5'd0, 8'h00);
        cycle();
        @(negedge clk);
        check("bcnt_clear", 32'(dbg_bcnt), 0);
        cycle();

        // Simultaneous from IDLE: CPU write first, then EXT reads it
        set_cpu(1'b1, 1'b1, 5'd3, 8'h44);
        set_ext(1'b1, 1'b0, 5'd3, 8'h00);
        push_gnt(1'b1, 1'b0, 1'b1, 5'd3, 8'h44);
        push_gnt(1'b0, 1'b1, 1'b0, 5'd3, 8'h00);
        push_rd(1'b0, 8'h44);
        cycle();
        set_cpu(1'b0, 1'b0, 5'd0, 8'h00);
        cycle();
        set_ext(1'b0, 1'b0, 5'd0, 8'h00);
        cycle();
        cycle();

        // Reset right after a read grant: no valid, rdata cleared
        set_cpu(1'b1, 1'b0, 5'd5, 8'h00);
        push_gnt(1'b1, 1'b0, 1'b0, 5'd5, 8'h00);
        cycle();
        rst = 1'b1;
        set_ext(1'b1, 1'b0, 5'd9, 8'h00);
        @(negedge clk);
        check("rst_mid_valid", 32'(cpu_if.valid), 0);
        check("rst_mid_rdata", 32'(cpu_if.rdata), 0);
        cycle();
        cycle();
        rst = 1'b0;
        set_cpu(1'b0, 1'b0, 5'd0, 8'h00);
        set_ext(1'b0, 1'b0, 5'd0, 8'h00);
        @(negedge clk);
        check("rst_rdata_cleared", 32'(cpu_if.rdata), 0);
        cycle();
        set_cpu(1'b1, 1'b0, 5'd31, 8'h00);
        push_gnt(1'b1, 1'b0, 1'b0, 5'd31, 8'h00);
        push_rd(1'b1, 8'hA5);
        cycle();
        set_cpu(1'b0, 1'b0, 5'd0, 8'h00);
        cycle();
        cycle();

`ifdef ARB_EXT_LOCK_EN
        // EXT wins, then holds the memory under ext_lock for 10 cycles
        set_ext(1'b1, 1'b0, 5'd31, 8'h00);
        push_gnt(1'b0, 1'b1, 1'b0, 5'd31, 8'h00);
        push_rd(1'b0, 8'hA5);
        cycle();
        ext_lock = 1'b1;
        set_cpu(1'b1, 1'b0, 5'd5, 8'h00);
        for (int i = 0; i < 10; i++) begin
            push_gnt(1'b0, 1'b1, 1'b0, 5'd31, 8'h00);
            push_rd(1'b0, 8'hA5);
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 6) begin
                @(negedge clk);
                check("lock_bcnt", 32'(dbg_bcnt), 0);
            end
            cycle();
        end
        ext_lock = 1'b0;
        push_gnt(1'b1, 1'b0, 1'b0, 5'd5, 8'h00);
        push_rd(1'b1, 8'h3C);
        cycle();
        set_cpu(1'b0, 1'b0, 5'd0, 8'h00);
        set_ext(1'b0, 1'b0, 5'd0, 8'h00);
        cycle();
        cycle();
`endif

        cycle();
        check("grant_queue_empty", 32'(exp_q.size()), 0);
        check("rdata_queue_empty", 32'(exp_rd_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
